// File: rtl/ram_pkg.sv
// Shared types and constants for the synchronous-clear dual-port RAM.
// Imported by the clear sequencer and the RAM top level.
package ram_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR,
        ST_READY
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, then parks in ST_READY until the next
// reset.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: ;
            default:  state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        init_busy = (state_q == ST_CLEAR);
        clr_we    = (state_q == ST_CLEAR);
        clr_addr  = cnt_q;
    end

endmodule

// File: rtl/ram_dp_sync_clr.sv
// Simple dual-port synchronous RAM with a post-reset clear sweep, registered read with a valid
// strobe and selectable read-during-write behaviour.
module ram_dp_sync_clr
    import ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 4,
    parameter int unsigned           DEPTH       = 16,
    parameter int unsigned           ADDR_WIDTH  = $clog2(DEPTH),
    parameter int unsigned           RDW_MODE    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_in_range, rd_in_range;
    logic                  user_we, user_re;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    ram_clear_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // Only non-power-of-two depths can see addresses past the end of the array.
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign user_we     = !init_busy && wr_en && wr_in_range;
    assign user_re     = !init_busy && rd_en;

    always_comb begin
        mem_we    = clr_we | user_we;
        mem_waddr = init_busy ? clr_addr : wr_addr;
        mem_wdata = init_busy ? CLEAR_VALUE : wr_data;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_word = CLEAR_VALUE;
        if (rd_in_range) begin
            if ((RDW_MODE == RDW_NEW) && user_we && (wr_addr == rd_addr)) begin
                rd_word = wr_data;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= user_re;
            if (user_re) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
